// File: rtl/req_encoder_4x2.sv
// Four-line request encoder with sticky pending bits and a valid/ready output handshake.
// Define ROUND_ROBIN_EN for round-robin selection; the default build uses fixed priority d1 > d2 > d3 > d4.
module req_encoder_4x2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic d4,
  input  logic ready,
  output logic a,
  output logic b,
  output logic valid,
  output logic busy
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_OUT = 1'b1} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_pend;
  logic [3:0] w_set;
  logic [3:0] w_cap;
  logic [3:0] w_grant;
  logic [1:0] r_code;
  logic [1:0] w_idx;
  logic       w_any;
  logic       w_load;

  // Bit 0 is d1 and bit 3 is d4, so the output code is simply the inverted index.
  assign w_set = en ? {d4, d3, d2, d1} : 4'b0000;
  assign w_cap = r_pend | w_set;

`ifdef ROUND_ROBIN_EN
  logic [1:0] r_ptr;

  function automatic logic [2:0] pick(input logic [3:0] cand, input logic [1:0] start);
    logic [1:0] k;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      k = start + 2'(i);
      if (cand[k]) begin
        res = {1'b1, k};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Pick the first candidate at or after the search pointer.
  always_comb begin
    {w_any, w_idx} = pick(w_cap, r_ptr);
  end
`else
  function automatic logic [2:0] pick(input logic [3:0] cand);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (cand[i]) begin
        res = {1'b1, 2'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Pick the lowest-index candidate.
  always_comb begin
    {w_any, w_idx} = pick(w_cap);
  end
`endif

  assign w_grant = w_load ? (4'b0001 << w_idx) : 4'b0000;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and load decision; IDLE only selects once something was already pending.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend != 4'b0000) begin
          w_load      = 1'b1;
          w_state_nxt = S_OUT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_OUT: begin
        if (ready) begin
          w_load      = w_any;
          w_state_nxt = w_any ? S_OUT : S_IDLE;
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pending bits, held code and pointer; a fresh request on the granted line keeps it pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 4'b0000;
      r_code <= 2'b00;
`ifdef ROUND_ROBIN_EN
      r_ptr  <= 2'd0;
`endif
    end else begin
      r_pend <= (r_pend & ~w_grant) | w_set;
      if (w_load) begin
        r_code <= ~w_idx;
`ifdef ROUND_ROBIN_EN
        r_ptr  <= w_idx + 2'd1;
`endif
      end else begin
        r_code <= r_code;
      end
    end
  end

  // Output decode.
  always_comb begin
    a     = r_code[1];
    b     = r_code[0];
    valid = (r_state == S_OUT);
    busy  = (r_pend != 4'b0000);
  end

endmodule

// File: tb/tb_req_encoder_4x2.sv
// Directed self-checking bench for req_encoder_4x2; inputs change and outputs are sampled 1ns after posedge.
module tb_req_encoder_4x2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, d1 = 1'b0, d2 = 1'b0, d3 = 1'b0, d4 = 1'b0, ready = 1'b0;
  logic a, b, valid, busy;
  int errors = 0;
  int checks = 0;

  req_encoder_4x2 dut (
    .clk(clk), .rst(rst), .en(en), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
    .ready(ready), .a(a), .b(b), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({a, b, valid, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got a,b,valid,busy=%b expected 0000", {a, b, valid, busy});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got valid,busy=%b expected 00", {valid, busy});
    end
  endtask

  task automatic test_single();
    en = 1'b1; ready = 1'b1; d3 = 1'b1;
    tick();
    d3 = 1'b0;
    checks++;
    if ({valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL single_capture: got valid,busy=%b expected 01", {valid, busy});
    end
    tick();
    checks++;
    if ({valid, a, b} !== 3'b101) begin
      errors++;
      $display("FAIL single_code: got valid,a,b=%b expected 101", {valid, a, b});
    end
    tick();
    checks++;
    if ({valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_done: got valid,busy=%b expected 00", {valid, busy});
    end
  endtask

`ifndef ROUND_ROBIN_EN
  task automatic test_priority();
    logic [1:0] exp_codes [4];
    exp_codes = '{2'b11, 2'b10, 2'b01, 2'b00};
    ready = 1'b1;
    {d1, d2, d3, d4} = 4'b1111;
    tick();
    {d1, d2, d3, d4} = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({valid, a, b} !== {1'b1, exp_codes[i]}) begin
        errors++;
        $display("FAIL priority_%0d: got valid,a,b=%b expected %b", i, {valid, a, b}, {1'b1, exp_codes[i]});
      end
    end
    tick();
    checks++;
    if ({valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL priority_end: got valid,busy=%b expected 00", {valid, busy});
    end
  endtask
`else
  task automatic test_round_robin();
    logic [1:0] exp_codes [5];
    exp_codes = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b11};
    ready = 1'b1;
    d1 = 1'b1;
    tick();
    d3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({valid, a, b} !== {1'b1, exp_codes[i]}) begin
        errors++;
        $display("FAIL rr_%0d: got valid,a,b=%b expected %b", i, {valid, a, b}, {1'b1, exp_codes[i]});
      end
    end
    d1 = 1'b0; d3 = 1'b0;
    tick();
    checks++;
    if ({valid, a, b} !== 3'b101) begin
      errors++;
      $display("FAIL rr_drain0: got valid,a,b=%b expected 101", {valid, a, b});
    end
    tick();
    checks++;
    if ({valid, a, b} !== 3'b111) begin
      errors++;
      $display("FAIL rr_drain1: got valid,a,b=%b expected 111", {valid, a, b});
    end
    tick();
    checks++;
    if ({valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rr_end: got valid,busy=%b expected 00", {valid, busy});
    end
  endtask
`endif

  task automatic test_backpressure();
    ready = 1'b0; d2 = 1'b1;
    tick();
    d2 = 1'b0;
    tick();
    checks++;
    if ({valid, a, b} !== 3'b110) begin
      errors++;
      $display("FAIL bp_first: got valid,a,b=%b expected 110", {valid, a, b});
    end
    d4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      d4 = 1'b0;
      checks++;
      if ({valid, a, b, busy} !== 4'b1101) begin
        errors++;
        $display("FAIL bp_stall_%0d: got valid,a,b,busy=%b expected 1101", i, {valid, a, b, busy});
      end
    end
    ready = 1'b1;
    tick();
    checks++;
    if ({valid, a, b, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL bp_next: got valid,a,b,busy=%b expected 1000", {valid, a, b, busy});
    end
    tick();
    checks++;
    if ({valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL bp_end: got valid,busy=%b expected 00", {valid, busy});
    end
  endtask

  task automatic test_gating();
    en = 1'b0; d2 = 1'b1; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL gate_%0d: got valid,busy=%b expected 00", i, {valid, busy});
      end
    end
    d2 = 1'b0; en = 1'b1;
    tick();
    tick();
    checks++;
    if ({valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL gate_after: got valid,busy=%b expected 00", {valid, busy});
    end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0; d1 = 1'b1; d4 = 1'b1;
    tick();
    d1 = 1'b0; d4 = 1'b0;
    tick();
    checks++;
    if ({valid, a, b, busy} !== 4'b1111) begin
      errors++;
      $display("FAIL mid_loaded: got valid,a,b,busy=%b expected 1111", {valid, a, b, busy});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({valid, a, b, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_async: got valid,a,b,busy=%b expected 0000", {valid, a, b, busy});
    end
    tick();
    rst = 1'b0; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL mid_stale_%0d: got valid,busy=%b expected 00", i, {valid, busy});
      end
    end
    d4 = 1'b1;
    tick();
    d4 = 1'b0;
    tick();
    checks++;
    if ({valid, a, b} !== 3'b100) begin
      errors++;
      $display("FAIL mid_recover: got valid,a,b=%b expected 100", {valid, a, b});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
`ifndef ROUND_ROBIN_EN
    test_priority();
`else
    test_round_robin();
`endif
    test_backpressure();
    test_gating();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/req_encoder_4x2.md
REQ_ENCODER_4X2 -- requirements
Module: req_encoder_4x2

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk input 1 (rising-edge clock); rst input 1 (asynchronous, active-high reset).
REQ-002 The block SHALL have input en, 1 bit: request capture enable; d1..d4 are ignored while en=0.
REQ-003 The block SHALL have inputs d1, d2, d3, d4, 1 bit each: request lines; any combination may be high in one cycle.
REQ-004 The block SHALL have input ready, 1 bit: the consumer accepts the current code when ready=1 and valid=1 in the same cycle.
REQ-005 The block SHALL have outputs a and b, 1 bit each: registered 2-bit code {a,b}, mapped d4=00, d3=01, d2=10, d1=11.
REQ-006 The block SHALL have output valid, 1 bit: {a,b} holds an unaccepted code.
REQ-007 The block SHALL have output busy, 1 bit: OR of the four pending bits.

Function
REQ-008 The block SHALL keep a 4-bit pending register, one bit per request line.
- Each rising edge ORs in {d1,d2,d3,d4} gated by en.
REQ-009 The state machine SHALL have two states: IDLE (valid=0) and OUT (valid=1).
REQ-010 In IDLE with at least one pending bit set, the next edge SHALL do all of the following:
- select one pending bit per REQ-013
- load its code into {a,b}
- clear that pending bit
- enter OUT
REQ-011 In OUT with ready=0, a, b and valid SHALL hold stable.
REQ-012 In OUT with ready=1:
- if any pending bit remains set after the edge-N capture, the block SHALL load the next code back-to-back and stay in OUT
- otherwise it SHALL enter IDLE with valid=0
REQ-013 Without ROUND_ROBIN_EN, selection SHALL use fixed priority d1 > d2 > d3 > d4.
REQ-014 Latency SHALL be one cycle: a request sampled at edge N, with the block in IDLE and no older pending bits, gives valid=1 with its code after edge N+1.
REQ-015 Requests arriving while in OUT SHALL be captured into pending and SHALL never be lost.
REQ-016 Repeated requests on a line whose bit is already set SHALL merge into that single pending bit.
REQ-017 If a line's pending bit is cleared on the same edge the same line requests again, set SHALL win and the bit SHALL stay pending.
REQ-018 Requests in IDLE are captured into pending at edge N and selected at edge N+1. On that selection edge, capture SHALL take effect before selection, so any requests presented at that edge are also candidates.
REQ-019 busy SHALL be combinational from the pending register only.

Reset
REQ-020 While rst=1, the block SHALL force the following immediately, independent of clk:
- pending=0000
- a=0, b=0
- valid=0
- busy=0
- state=IDLE
- round-robin pointer=d1
REQ-021 A reset asserted mid-operation SHALL discard the held code and all pending requests.
REQ-022 The first capture after reset SHALL be at the first rising clk edge after rst deasserts.

Configuration
REQ-023 When macro ROUND_ROBIN_EN is defined, selection SHALL be round-robin.
- Search starts at the line after the last granted line, in cyclic order d1, d2, d3, d4, d1.
- The pointer updates only on a load.
REQ-024 When ROUND_ROBIN_EN is undefined, there SHALL be no pointer logic and REQ-013 SHALL apply.
REQ-025 The port list, latency and reset behaviour SHALL be identical in both configurations.

Verification
REQ-026 The bench SHALL cover single request:
- stimulus: reset, en=1, pulse d3 for one cycle, ready=1
- response: next cycle valid=1, {a,b}=01; following cycle valid=0, busy=0
REQ-027 The bench SHALL cover fixed priority (macro off):
- stimulus: pulse d1..d4 together, ready=1
- response: codes 11, 10, 01, 00 on four consecutive cycles, then valid=0
REQ-028 The bench SHALL cover round-robin (macro on):
- stimulus: d1 grant first, then hold d1 and d3 high continuously with ready=1
- response: codes alternate 01, 11, 01, 11 and d1 never wins twice in a row
REQ-029 The bench SHALL cover backpressure:
- stimulus: ready=0 for 5 cycles after code 10 appears; d4 pulses during the stall; then ready=1
- response: {a,b}=10 stable for the 5 cycles, busy=1, then 00 appears
REQ-030 The bench SHALL cover gating and reset:
- stimulus: en=0 with d2=1 -> response: valid and busy stay 0
- stimulus: rst pulse mid-OUT, between clock edges -> response: valid=0, a=b=0, busy=0 immediately, no stale codes afterwards
